// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline: load-use, memory wait, timeout, redirect.
// Optional performance counters are compiled in when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int RegAddrWidth = 5,
  parameter int MEM_TIMEOUT  = 255,
  parameter int TO_W         = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    id_valid,
  input  logic [RegAddrWidth-1:0] id_rs1_addr,
  input  logic [RegAddrWidth-1:0] id_rs2_addr,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic                    ex_valid,
  input  logic                    ex_is_load,
  input  logic [RegAddrWidth-1:0] ex_rd_addr,
  input  logic                    ex_redirect,
  input  logic                    mem_req,
  input  logic                    mem_ack,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    stall_ex,
  output logic                    stall_mem,
  output logic                    flush_id,
  output logic                    flush_ex,
  output logic                    bubble_wb,
  output logic                    redirect_take,
  output logic                    mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_flush_count
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  localparam logic [TO_W-1:0] CNT_MAX     = '1;
  localparam logic [TO_W-1:0] CNT_ONE     = TO_W'(1);
  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  logic [1:0]      state, state_nxt;
  logic [TO_W-1:0] counter, counter_nxt;
  logic            redirect_pending, redirect_pending_nxt;
  logic            timeout_nxt;
  logic            load_use;

  logic s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, r_take;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use = ex_valid & ex_is_load & (ex_rd_addr != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                     (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nxt            = state;
    counter_nxt          = counter;
    redirect_pending_nxt = redirect_pending;
    timeout_nxt          = mem_timeout;
    s_if   = 1'b0;
    s_id   = 1'b0;
    s_ex   = 1'b0;
    s_mem  = 1'b0;
    f_id   = 1'b0;
    f_ex   = 1'b0;
    b_wb   = 1'b0;
    r_take = 1'b0;

    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
          state_nxt            = ST_MEM_WAIT;
          counter_nxt          = CNT_ONE;
          redirect_pending_nxt = ex_redirect;
        end else if (ex_redirect && ex_valid) begin
          // Redirect beats load-use: the dependent instruction is squashed anyway.
          {r_take, f_id, f_ex} = 3'b111;
        end else if (load_use) begin
          {s_if, s_id, f_ex} = 3'b111;
        end
      end

      ST_MEM_WAIT, ST_TIMEOUT: begin
        if (!mem_ack) begin
          {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
          redirect_pending_nxt = redirect_pending | ex_redirect;
          if (state == ST_MEM_WAIT) begin
            if (counter != CNT_MAX) counter_nxt = counter + CNT_ONE;
            if (counter == TIMEOUT_VAL) begin
              state_nxt   = ST_TIMEOUT;
              timeout_nxt = 1'b1;
            end
          end
        end else begin
          // A redirect seen during the freeze is replayed exactly once, in the ack cycle.
          state_nxt            = ST_RUN;
          counter_nxt          = '0;
          redirect_pending_nxt = 1'b0;
          if (redirect_pending || ex_redirect) begin
            {r_take, f_id, f_ex} = 3'b111;
          end else if (load_use) begin
            {s_if, s_id, f_ex} = 3'b111;
          end
        end
      end

      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= ST_RUN;
      counter          <= '0;
      redirect_pending <= 1'b0;
      mem_timeout      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state            <= state_nxt;
      counter          <= counter_nxt;
      redirect_pending <= redirect_pending_nxt;
      mem_timeout      <= timeout_nxt;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall_if      = nrst & s_if;
  assign stall_id      = nrst & s_id;
  assign stall_ex      = nrst & s_ex;
  assign stall_mem     = nrst & s_mem;
  assign flush_id      = nrst & f_id;
  assign flush_ex      = nrst & f_ex;
  assign bubble_wb     = nrst & b_wb;
  assign redirect_take = nrst & r_take;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall_if)      perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_take) perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=8); perf counters checked when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       ex_valid, ex_is_load, ex_redirect, mem_req, mem_ack;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, bubble_wb, redirect_take, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int total = 0;
  int bad   = 0;

  // Bit order: stall_if stall_id stall_ex stall_mem flush_id flush_ex bubble_wb redirect_take
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_0100;
  localparam logic [7:0] O_MEMW = 8'b1111_0010;
  localparam logic [7:0] O_RED  = 8'b0000_1101;

  pipe_hazard_ctrl #(.RegAddrWidth(5), .MEM_TIMEOUT(8), .TO_W(16)) dut (
    .clk(clk), .nrst(nrst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb),
    .redirect_take(redirect_take), .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, redirect_take};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    ex_valid = 0; ex_is_load = 0; ex_redirect = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_lu();
    id_valid = 1; id_uses_rs1 = 0; id_uses_rs2 = 1;
    id_rs1_addr = 5'd3; id_rs2_addr = 5'd5;
    ex_valid = 1; ex_is_load = 1; ex_rd_addr = 5'd5;
  endtask

  task automatic pulse_reset();
    nrst = 0; #2; nrst = 1; #1;
  endtask

  task automatic test_reset();
    set_lu(); mem_req = 1; ex_redirect = 1;
    nrst = 0; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), O_NONE); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    set_idle(); #1; nrst = 1;
    tick();
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL idle_outs got=%b exp=%b", outs(), O_NONE); end
  endtask

  task automatic test_load_use();
    set_lu(); #1;
    total++; if (outs() !== O_LU) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", outs(), O_LU); end
    tick();
    // The load has moved to MEM; EX now holds the bubble.
    ex_valid = 0; ex_is_load = 0; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL lu_clears got=%b exp=%b", outs(), O_NONE); end
    tick();
    set_lu(); ex_rd_addr = 0; id_rs2_addr = 0; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", outs(), O_NONE); end
    tick();
    set_lu(); id_uses_rs2 = 0; id_rs1_addr = 5'd5; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL lu_rs1_unused got=%b exp=%b", outs(), O_NONE); end
    id_uses_rs1 = 1; #1;
    total++; if (outs() !== O_LU) begin bad++; $display("FAIL lu_rs1 got=%b exp=%b", outs(), O_LU); end
    id_valid = 0; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL lu_id_invalid got=%b exp=%b", outs(), O_NONE); end
    tick(); set_idle();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ack = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      total++; if (outs() !== O_MEMW) begin bad++; $display("FAIL wait_cycle%0d got=%b exp=%b", i, outs(), O_MEMW); end
      tick();
    end
    mem_ack = 1; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL wait_ack got=%b exp=%b", outs(), O_NONE); end
    tick();
    mem_req = 0; mem_ack = 0; ex_valid = 1; ex_redirect = 1; #1;
    total++; if (outs() !== O_RED) begin bad++; $display("FAIL wait_back_run got=%b exp=%b", outs(), O_RED); end
    tick(); set_idle();
    mem_req = 1; mem_ack = 1; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL zero_wait got=%b exp=%b", outs(), O_NONE); end
    tick(); set_idle(); #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL zero_wait_after got=%b exp=%b", outs(), O_NONE); end
    tick();
  endtask

  task automatic test_redirect_load_use();
    set_lu(); ex_redirect = 1; #1;
    total++; if (outs() !== O_RED) begin bad++; $display("FAIL red_over_lu got=%b exp=%b", outs(), O_RED); end
    ex_valid = 0; #1;
    // Without ex_valid neither the redirect nor the load-use applies.
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL red_invalid got=%b exp=%b", outs(), O_NONE); end
    tick(); set_idle();
  endtask

  task automatic test_redirect_during_wait();
    mem_req = 1; mem_ack = 0;
    for (int i = 1; i <= 4; i++) begin
      ex_redirect = (i == 2); #1;
      total++; if (outs() !== O_MEMW) begin bad++; $display("FAIL rdw_wait%0d got=%b exp=%b", i, outs(), O_MEMW); end
      tick();
    end
    ex_redirect = 0; mem_ack = 1; #1;
    total++; if (outs() !== O_RED) begin bad++; $display("FAIL rdw_ack got=%b exp=%b", outs(), O_RED); end
    tick(); set_idle(); #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL rdw_once got=%b exp=%b", outs(), O_NONE); end
    tick();
  endtask

  task automatic test_ack_load_use();
    mem_req = 1; tick();
    mem_ack = 1; set_lu(); #1;
    total++; if (outs() !== O_LU) begin bad++; $display("FAIL ack_lu got=%b exp=%b", outs(), O_LU); end
    tick(); set_idle();
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ack = 0;
    // Detection cycle in RUN plus 8 wait cycles (counter 1..8) before the flag rises.
    for (int i = 1; i <= 9; i++) begin
      #1;
      total++; if (mem_timeout !== 1'b0 || outs() !== O_MEMW) begin
        bad++; $display("FAIL to_pre%0d got=%b/%b exp=0/%b", i, mem_timeout, outs(), O_MEMW);
      end
      tick();
    end
    for (int i = 1; i <= 3; i++) begin
      #1;
      total++; if (mem_timeout !== 1'b1 || outs() !== O_MEMW) begin
        bad++; $display("FAIL to_hold%0d got=%b/%b exp=1/%b", i, mem_timeout, outs(), O_MEMW);
      end
      tick();
    end
    mem_ack = 1; tick();
    set_idle(); ex_valid = 1; ex_redirect = 1; #1;
    total++; if (mem_timeout !== 1'b1 || outs() !== O_RED) begin
      bad++; $display("FAIL to_late_ack got=%b/%b exp=1/%b", mem_timeout, outs(), O_RED);
    end
    tick(); set_idle();
    pulse_reset();
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_cleared got=%b exp=0", mem_timeout); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1; tick(); tick();
    nrst = 0; #1;
    total++; if (outs() !== O_NONE) begin bad++; $display("FAIL midrst_outs got=%b exp=%b", outs(), O_NONE); end
    mem_req = 0; nrst = 1; #1;
    ex_valid = 1; ex_redirect = 1; #1;
    total++; if (outs() !== O_RED) begin bad++; $display("FAIL midrst_run got=%b exp=%b", outs(), O_RED); end
    tick(); set_idle();
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    set_idle(); pulse_reset();
    total++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_stall_cycles, perf_flush_count);
    end
    mem_req = 1; tick(); tick(); tick();
    mem_ack = 1; tick(); set_idle();
    set_lu(); tick(); set_idle();
    ex_valid = 1; ex_redirect = 1; tick(); set_idle();
    tick();
    total++; if (perf_stall_cycles !== 32'd4 || perf_flush_count !== 32'd1) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d exp=4/1", perf_stall_cycles, perf_flush_count);
    end
  endtask
`endif

  initial begin
    set_idle();
    nrst = 0;
    #12;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect_load_use();
    test_redirect_during_wait();
    test_ack_load_use();
    test_timeout();
    test_reset_mid_wait();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
